// File: rtl/dut_query_ctrl.sv
// Host-side oracle query sequencer: collects an input+key vector byte-wise, drives the
// locked DUT, waits a fixed settle interval, then returns the captured result byte-wise.
module dut_query_ctrl #(
  parameter int IN_W    = 51,
  parameter int OUT_W   = 7,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [IN_W-1:0]  dut_inputs,
  input  logic [OUT_W-1:0] dut_outputs,
  output logic             busy,
  output logic             frame_err,
  output logic [15:0]      query_count
);

  localparam int NB_IN  = (IN_W + 7) / 8;
  localparam int NB_OUT = (OUT_W + 7) / 8;
  localparam int SH_W   = 8 * NB_IN;
  localparam int RS_W   = 8 * NB_OUT;
  localparam int BI_W   = (NB_IN > 1)   ? $clog2(NB_IN)   : 1;
  localparam int TI_W   = (NB_OUT > 1)  ? $clog2(NB_OUT)  : 1;
  localparam int SC_W   = (SETTLE > 1)  ? $clog2(SETTLE)  : 1;
  localparam int GP_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_SETTLE,
    S_SEND
  } state_e;

  state_e            state_q,     state_d;
  logic [BI_W-1:0]   byte_idx_q,  byte_idx_d;
  logic [IN_W-1:0]   shadow_q,    shadow_d;
  logic [IN_W-1:0]   dut_in_q,    dut_in_d;
  logic [SC_W-1:0]   settle_q,    settle_d;
  logic [GP_W-1:0]   gap_q,       gap_d;
  logic [RS_W-1:0]   resp_q,      resp_d;
  logic [TI_W-1:0]   tx_idx_q,    tx_idx_d;
  logic [15:0]       qcount_q,    qcount_d;
  logic              frame_err_q, frame_err_d;

  logic [SH_W-1:0]   byte_ext;
  logic [SH_W-1:0]   byte_mask;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    shadow_d    = shadow_q;
    dut_in_d    = dut_in_q;
    settle_d    = settle_q;
    gap_d       = gap_q;
    resp_d      = resp_q;
    tx_idx_d    = tx_idx_q;
    qcount_d    = qcount_q;
    frame_err_d = 1'b0;
    rx_ready    = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;

    byte_ext  = SH_W'(rx_data) << {byte_idx_q, 3'b000};
    byte_mask = SH_W'(8'hFF)   << {byte_idx_q, 3'b000};

    case (state_q)
      S_COLLECT: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          // Bits of the final byte beyond IN_W fall off in the truncating cast.
          shadow_d = IN_W'((SH_W'(shadow_q) & ~byte_mask) | byte_ext);
          gap_d    = '0;
          if (byte_idx_q == BI_W'(NB_IN - 1)) begin
            dut_in_d   = shadow_d;
            byte_idx_d = '0;
            settle_d   = '0;
            state_d    = S_SETTLE;
          end else begin
            byte_idx_d = byte_idx_q + BI_W'(1);
          end
        end else if (TIMEOUT > 0 && byte_idx_q != '0) begin
          if (gap_q == GP_W'(TIMEOUT - 1)) begin
            byte_idx_d  = '0;
            shadow_d    = '0;
            gap_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            gap_d = gap_q + GP_W'(1);
          end
        end
      end

      S_SETTLE: begin
        settle_d = settle_q + SC_W'(1);
        if (settle_q == SC_W'(SETTLE - 1)) begin
          resp_d   = RS_W'(dut_outputs);
          settle_d = '0;
          state_d  = S_SEND;
        end
      end

      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = 8'(resp_q >> {tx_idx_q, 3'b000});
        if (tx_ready) begin
          if (tx_idx_q == TI_W'(NB_OUT - 1)) begin
            tx_idx_d = '0;
            qcount_d = qcount_q + 16'd1;
            state_d  = S_COLLECT;
          end else begin
            tx_idx_d = tx_idx_q + TI_W'(1);
          end
        end
      end

      default: state_d = S_COLLECT;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      byte_idx_q  <= '0;
      // NOTE: the shadow and response registers are reset too, since a partial frame
      // must never leak into a later query after an abort.
      shadow_q    <= '0;
      dut_in_q    <= '0;
      settle_q    <= '0;
      gap_q       <= '0;
      resp_q      <= '0;
      tx_idx_q    <= '0;
      qcount_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      shadow_q    <= shadow_d;
      dut_in_q    <= dut_in_d;
      settle_q    <= settle_d;
      gap_q       <= gap_d;
      resp_q      <= resp_d;
      tx_idx_q    <= tx_idx_d;
      qcount_q    <= qcount_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign dut_inputs  = dut_in_q;
  assign busy        = (state_q != S_COLLECT);
  assign frame_err   = frame_err_q;
  assign query_count = qcount_q;

endmodule
